// File: rtl/liang_pkg.sv
// Shared pipeline types and register-file constants for the liang core.
package liang_pkg;

    localparam int XLEN       = 32;
    localparam int NR_REGS    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_A0     = 10;

    typedef struct packed {
        logic                  rd_wen;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rd_wdata;
    } wb_req_t;

endpackage

// File: rtl/pipe_scoreboard.sv
// Per-register in-flight writer counters with flush and two bypass-aware busy queries.
module pipe_scoreboard
    import liang_pkg::*;
#(
    parameter int NR_REGS_P = NR_REGS,
    parameter int CNT_W     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inc_i,
    input  logic [REG_ADDR_W-1:0] inc_idx_i,
    input  logic                  dec_i,
    input  logic [REG_ADDR_W-1:0] dec_idx_i,
    input  logic                  flush_i,
    input  logic [REG_ADDR_W-1:0] q1_idx_i,
    input  logic [REG_ADDR_W-1:0] q2_idx_i,
    output logic                  busy1_o,
    output logic                  busy2_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [NR_REGS_P];
    logic [CNT_W-1:0] cnt_d [NR_REGS_P];
    logic             inc_full_s;

    // A writer retiring this cycle no longer counts, so its consumer sees the bypass instead
    function automatic logic busy_f(input logic [CNT_W-1:0] cnt,
                                    input logic [REG_ADDR_W-1:0] idx,
                                    input logic dec,
                                    input logic [REG_ADDR_W-1:0] dec_idx);
        logic [CNT_W-1:0] retire;
        retire = {{(CNT_W-1){1'b0}}, (dec && (dec_idx == idx))};
        return (idx != {REG_ADDR_W{1'b0}}) && (cnt > retire);
    endfunction

    // Next-state counters: flush wins, matched inc/dec cancel, both ends saturate
    always_comb begin
        for (int r = 0; r < NR_REGS_P; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush_i) begin
                cnt_d[r] = {CNT_W{1'b0}};
            end else if (inc_i && (inc_idx_i == REG_ADDR_W'(r))
                         && !(dec_i && (dec_idx_i == REG_ADDR_W'(r)))) begin
                if (cnt_q[r] != CNT_MAX) begin
                    cnt_d[r] = cnt_q[r] + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d[r] = cnt_q[r];
                end
            end else if (dec_i && (dec_idx_i == REG_ADDR_W'(r))
                         && !(inc_i && (inc_idx_i == REG_ADDR_W'(r)))) begin
                if (cnt_q[r] != {CNT_W{1'b0}}) begin
                    cnt_d[r] = cnt_q[r] - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d[r] = cnt_q[r];
                end
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
    end

    // Counter state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NR_REGS_P; r++) begin
                cnt_q[r] <= {CNT_W{1'b0}};
            end
        end else begin
            for (int r = 0; r < NR_REGS_P; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign busy1_o    = busy_f(cnt_q[q1_idx_i], q1_idx_i, dec_i, dec_idx_i);
    assign busy2_o    = busy_f(cnt_q[q2_idx_i], q2_idx_i, dec_i, dec_idx_i);
    assign inc_full_s = (cnt_q[inc_idx_i] == CNT_MAX);

    pipe_scoreboard_chk u_chk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (inc_i),
        .inc_full_i (inc_full_s)
    );

endmodule

// File: rtl/pipe_scoreboard_chk.sv
// Simulation checker: decode must never issue to a register whose in-flight counter is full.
module pipe_scoreboard_chk (
    input logic clk_i,
    input logic rst_i,
    input logic inc_i,
    input logic inc_full_i
);

    // Overflow of a scoreboard counter means decode exceeded the supported depth
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(inc_i && inc_full_i))
        else $error("scoreboard counter overflow on issue");

endmodule

// File: rtl/pipe_regfile.sv
// Architectural integer register file with writeback bypass, RAW scoreboard and a0 tap.
module pipe_regfile
    import liang_pkg::*;
#(
    parameter int XLEN_P    = XLEN,
    parameter int NR_REGS_P = NR_REGS,
    parameter int CNT_W     = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  wb_req_t               wb_req_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic [XLEN_P-1:0]     rs1_rdata_o,
    output logic [XLEN_P-1:0]     rs2_rdata_o,
    input  logic                  issue_i,
    input  logic                  issue_rd_wen_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic                  flush_i,
    output logic                  raw_stall_o,
    output logic [XLEN_P-1:0]     a0_o
);

    logic [XLEN_P-1:0] regs_q [NR_REGS_P];
    logic              wen_s;
    logic              inc_s;
    logic              busy1_s;
    logic              busy2_s;

    assign wen_s = wb_req_i.rd_wen && (wb_req_i.rd != {REG_ADDR_W{1'b0}});
    assign inc_s = issue_i && issue_rd_wen_i && (issue_rd_i != {REG_ADDR_W{1'b0}});

    function automatic logic [XLEN_P-1:0] read_f(input logic [REG_ADDR_W-1:0] idx,
                                                 input logic [XLEN_P-1:0] stored,
                                                 input logic wen,
                                                 input wb_req_t req);
        if (idx == {REG_ADDR_W{1'b0}}) begin
            return {XLEN_P{1'b0}};
        end else if (wen && (req.rd == idx)) begin
            return XLEN_P'(req.rd_wdata);
        end else begin
            return stored;
        end
    endfunction

    // Register storage; flush does not cancel a commit already in writeback
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NR_REGS_P; r++) begin
                regs_q[r] <= {XLEN_P{1'b0}};
            end
        end else if (wen_s) begin
            regs_q[wb_req_i.rd] <= XLEN_P'(wb_req_i.rd_wdata);
        end
    end

    assign rs1_rdata_o = read_f(rs1_i, regs_q[rs1_i], wen_s, wb_req_i);
    assign rs2_rdata_o = read_f(rs2_i, regs_q[rs2_i], wen_s, wb_req_i);
    assign a0_o        = regs_q[REG_A0];
    assign raw_stall_o = busy1_s || busy2_s;

    pipe_scoreboard #(
        .NR_REGS_P (NR_REGS_P),
        .CNT_W     (CNT_W)
    ) u_scoreboard (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .inc_i     (inc_s),
        .inc_idx_i (issue_rd_i),
        .dec_i     (wen_s),
        .dec_idx_i (wb_req_i.rd),
        .flush_i   (flush_i),
        .q1_idx_i  (rs1_i),
        .q2_idx_i  (rs2_i),
        .busy1_o   (busy1_s),
        .busy2_o   (busy2_s)
    );

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed self-checking bench for pipe_regfile: reads, bypass, scoreboard, flush, reset.
module tb_pipe_regfile;
    import liang_pkg::*;

    logic        clk_i;
    logic        rst_i;
    wb_req_t     wb_req_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [31:0] rs1_rdata_o;
    logic [31:0] rs2_rdata_o;
    logic        issue_i;
    logic        issue_rd_wen_i;
    logic [4:0]  issue_rd_i;
    logic        flush_i;
    logic        raw_stall_o;
    logic [31:0] a0_o;

    int n_vec;
    int n_bad;

    pipe_regfile dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wb_req_i       (wb_req_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .rs1_rdata_o    (rs1_rdata_o),
        .rs2_rdata_o    (rs2_rdata_o),
        .issue_i        (issue_i),
        .issue_rd_wen_i (issue_rd_wen_i),
        .issue_rd_i     (issue_rd_i),
        .flush_i        (flush_i),
        .raw_stall_o    (raw_stall_o),
        .a0_o           (a0_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance past the next rising edge; inputs change 1 time unit after it
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
        wb_req_i.rd_wen   = en;
        wb_req_i.rd       = rd;
        wb_req_i.rd_wdata = d;
    endtask

    task automatic issue(input logic en, input logic [4:0] rd);
        issue_i        = en;
        issue_rd_wen_i = en;
        issue_rd_i     = rd;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        wb(1'b0, 5'd0, 32'd0);
        issue(1'b0, 5'd0);
        flush_i = 1'b0;
        rs1_i   = 5'd10;
        rs2_i   = 5'd5;
        tick();
        settle();
        n_vec++;
        if (rs1_rdata_o !== 32'd0 || rs2_rdata_o !== 32'd0 || raw_stall_o !== 1'b0 || a0_o !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: rs1=%h rs2=%h stall=%b a0=%h, want all 0",
                     rs1_rdata_o, rs2_rdata_o, raw_stall_o, a0_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        wb(1'b1, 5'd5, 32'hDEADBEEF);
        rs1_i = 5'd0;
        tick();
        wb(1'b0, 5'd0, 32'd0);
        rs1_i = 5'd5;
        settle();
        n_vec++;
        if (rs1_rdata_o !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL read_x5: got %h want deadbeef", rs1_rdata_o);
        end
        wb(1'b1, 5'd0, 32'h1234);
        rs1_i = 5'd0;
        settle();
        n_vec++;
        if (rs1_rdata_o !== 32'd0) begin
            n_bad++;
            $display("FAIL x0_bypass: got %h want 0", rs1_rdata_o);
        end
        tick();
        wb(1'b0, 5'd0, 32'd0);
        settle();
        n_vec++;
        if (rs1_rdata_o !== 32'd0) begin
            n_bad++;
            $display("FAIL x0_after_write: got %h want 0", rs1_rdata_o);
        end
    endtask

    task automatic test_bypass();
        wb(1'b1, 5'd7, 32'hA5A5A5A5);
        rs1_i = 5'd5;
        rs2_i = 5'd7;
        settle();
        n_vec++;
        if (rs2_rdata_o !== 32'hA5A5A5A5 || rs1_rdata_o !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL bypass_x7: rs2=%h want a5a5a5a5, rs1=%h want deadbeef", rs2_rdata_o, rs1_rdata_o);
        end
        tick();
        wb(1'b0, 5'd0, 32'd0);
        settle();
        n_vec++;
        if (rs2_rdata_o !== 32'hA5A5A5A5) begin
            n_bad++;
            $display("FAIL stored_x7: got %h want a5a5a5a5", rs2_rdata_o);
        end
    endtask

    task automatic test_raw_stall();
        rs1_i = 5'd0;
        rs2_i = 5'd0;
        issue(1'b1, 5'd3);
        tick();
        issue(1'b0, 5'd0);
        rs1_i = 5'd3;
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_x3: got %b want 1", raw_stall_o);
        end
        wb(1'b1, 5'd3, 32'h00000033);
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b0 || rs1_rdata_o !== 32'h00000033) begin
            n_bad++;
            $display("FAIL wb_bypass_x3: stall=%b want 0, data=%h want 00000033", raw_stall_o, rs1_rdata_o);
        end
        tick();
        wb(1'b0, 5'd0, 32'd0);
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL x3_retired: stall=%b want 0", raw_stall_o);
        end
    endtask

    task automatic test_back_to_back();
        rs1_i = 5'd0;
        rs2_i = 5'd4;
        issue(1'b1, 5'd4);
        tick();
        tick();
        issue(1'b0, 5'd0);
        wb(1'b1, 5'd4, 32'h4);
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL x4_two_pending: stall=%b want 1", raw_stall_o);
        end
        tick();
        wb(1'b0, 5'd0, 32'd0);
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL x4_one_pending: stall=%b want 1", raw_stall_o);
        end
        issue(1'b1, 5'd4);
        wb(1'b1, 5'd4, 32'h44);
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b0 || rs2_rdata_o !== 32'h44) begin
            n_bad++;
            $display("FAIL x4_issue_and_wb: stall=%b want 0, data=%h want 00000044", raw_stall_o, rs2_rdata_o);
        end
        tick();
        issue(1'b0, 5'd0);
        wb(1'b0, 5'd0, 32'd0);
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL x4_count_held: stall=%b want 1", raw_stall_o);
        end
        wb(1'b1, 5'd4, 32'h444);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL x4_drained: stall=%b want 0", raw_stall_o);
        end
    endtask

    task automatic test_flush();
        rs1_i = 5'd0;
        rs2_i = 5'd0;
        issue(1'b1, 5'd9);
        tick();
        issue(1'b1, 5'd12);
        tick();
        issue(1'b0, 5'd0);
        rs1_i = 5'd9;
        rs2_i = 5'd12;
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b1) begin
            n_bad++;
            $display("FAIL pre_flush: stall=%b want 1", raw_stall_o);
        end
        flush_i = 1'b1;
        issue(1'b1, 5'd12);
        wb(1'b1, 5'd12, 32'h0000000C);
        tick();
        flush_i = 1'b0;
        issue(1'b0, 5'd0);
        wb(1'b0, 5'd0, 32'd0);
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b0 || rs2_rdata_o !== 32'h0000000C) begin
            n_bad++;
            $display("FAIL post_flush: stall=%b want 0, x12=%h want 0000000c", raw_stall_o, rs2_rdata_o);
        end
        wb(1'b1, 5'd9, 32'h9);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        issue(1'b1, 5'd9);
        tick();
        issue(1'b0, 5'd0);
        wb(1'b1, 5'd9, 32'h99);
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_wb_no_underflow: stall=%b want 0", raw_stall_o);
        end
        tick();
        wb(1'b0, 5'd0, 32'd0);
        settle();
        n_vec++;
        if (raw_stall_o !== 1'b0 || rs1_rdata_o !== 32'h99) begin
            n_bad++;
            $display("FAIL x9_final: stall=%b want 0, data=%h want 00000099", raw_stall_o, rs1_rdata_o);
        end
    endtask

    task automatic test_reset_mid();
        rs1_i = 5'd0;
        rs2_i = 5'd0;
        wb(1'b1, 5'd10, 32'h55);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        settle();
        n_vec++;
        if (a0_o !== 32'h55) begin
            n_bad++;
            $display("FAIL a0_tap: got %h want 00000055", a0_o);
        end
        issue(1'b1, 5'd11);
        tick();
        issue(1'b0, 5'd0);
        rs1_i = 5'd11;
        rs2_i = 5'd10;
        rst_i = 1'b1;
        #1;
        n_vec++;
        if (a0_o !== 32'd0 || rs1_rdata_o !== 32'd0 || rs2_rdata_o !== 32'd0 || raw_stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: a0=%h rs1=%h rs2=%h stall=%b, want all 0",
                     a0_o, rs1_rdata_o, rs2_rdata_o, raw_stall_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        n_vec++;
        if (a0_o !== 32'd0 || rs2_rdata_o !== 32'd0 || raw_stall_o !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset: a0=%h rs2=%h stall=%b, want all 0", a0_o, rs2_rdata_o, raw_stall_o);
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_raw_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
